// File: rtl/delay_arbiter.sv
// Round-robin arbiter that lends one shared down-counter to NREQ requesters,
// one timed delay at a time, and pulses done for the winner when it expires.
module delay_arbiter #(
  parameter int NREQ  = 4,
  parameter int CBITS = 13,
  parameter int IDXW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CBITS-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [IDXW-1:0]       owner,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t           state;
  logic [CBITS-1:0] cnt;
  logic [IDXW-1:0]  ptr;

  logic [CBITS-1:0] len_arr [NREQ];
  logic [IDXW-1:0]  winner;
  logic             any_req;
  logic             gnt_multi;
  logic             done_with_gnt;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
      assign len_arr[gi] = len[gi*CBITS +: CBITS];
    end
  endgenerate

  // Walk from ptr upward with wrap; scanning the offsets high-to-low lets the
  // smallest offset with a pending request win.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    any_req = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        winner = IDXW'(idx);
      end
    end
  end

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
    if (int'(i) == NREQ - 1) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  assign gnt_multi     = (gnt & (gnt - ONE)) != '0;
  assign done_with_gnt = (done != '0) && (gnt != '0);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
      owner <= '0;
      gnt   <= '0;
      done  <= '0;
      err   <= 1'b0;
    end else begin
      // Sticky: any illegal output combination latches until reset.
      if (gnt_multi || done_with_gnt) begin
        err <= 1'b1;
      end
      case (state)
        IDLE: begin
          done <= '0;
          if (any_req) begin
            state <= RUN;
            gnt   <= ONE << winner;
            owner <= winner;
            cnt   <= len_arr[winner];
          end
        end
        RUN: begin
          if (!req[owner]) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= next_idx(owner);
          end else if (cnt == '0) begin
            state <= DONE;
            gnt   <= '0;
            done  <= ONE << owner;
            ptr   <= next_idx(owner);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done  <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          done  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed checks of grant timing, round-robin order, abort and reset for
// delay_arbiter, followed by a randomized invariant sweep.
module tb_delay_arbiter;

  localparam int NREQ  = 4;
  localparam int CBITS = 13;
  localparam int IDXW  = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*CBITS-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [IDXW-1:0]       owner;
  logic                  busy;
  logic                  err;

  int checks_cnt;
  int errors_cnt;

  delay_arbiter #(
    .NREQ (NREQ),
    .CBITS(CBITS),
    .IDXW (IDXW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .done (done),
    .owner(owner),
    .busy (busy),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input int v);
    len[i*CBITS +: CBITS] = CBITS'(v);
  endtask

  // Expects one grant from IDLE for exp_owner; measures latency and
  // grant length, then checks the done pulse and the return to IDLE.
  task automatic serve(input int exp_owner, input int exp_len);
    int waited;
    int cycles;
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << exp_owner;
    waited = 0;
    while (gnt == '0 && waited < 20) begin
      tick();
      waited++;
    end
    check("grant_latency", waited, 1);
    if (gnt == '0) return;
    check("grant_onehot", gnt, oh);
    check("grant_owner", owner, exp_owner);
    check("busy_run", busy, 1);
    cycles = 0;
    while (gnt != '0 && cycles < 9000) begin
      cycles++;
      tick();
    end
    check("grant_length", cycles, exp_len + 1);
    check("done_pulse", done, oh);
    check("busy_done", busy, 1);
    tick();
    check("done_clear", done, 0);
    check("busy_idle", busy, 0);
    $display("serve owner=%0d len=%0d wait=%0d gnt_cycles=%0d", exp_owner, exp_len, waited, cycles);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst = 1'b1;
    req = '0;
    len = '0;
    tick();
    tick();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick();
    check("idle_no_req", gnt, 0);

    // Single request, len=5
    set_len(0, 5);
    req = 4'b0001;
    serve(0, 5);
    req = '0;

    // Minimum length on requester 1 (ptr now 1)
    set_len(1, 0);
    req = 4'b0010;
    serve(1, 0);
    req = '0;

    // Abort: ptr=2, so 2 wins over 0 and 3; dropping it hands over to 3
    set_len(2, 100);
    set_len(3, 3);
    req = 4'b1101;
    tick();
    check("abort_gnt", gnt, 4'b0100);
    check("abort_owner", owner, 2);
    repeat (9) tick();
    check("abort_hold", gnt, 4'b0100);
    req[2] = 1'b0;
    tick();
    check("abort_gnt_clear", gnt, 0);
    check("abort_no_done", done, 0);
    check("abort_busy", busy, 0);
    serve(3, 3);
    req = '0;
    $display("abort owner=2 then owner=3");

    // Maximum length on requester 1 (ptr now 0)
    set_len(1, 8191);
    req = 4'b0010;
    serve(1, 8191);
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("max_no_extra_done", done, 0);
    end

    // Reset mid-RUN: ptr is 2 before reset; after reset 0 must beat 3
    set_len(2, 50);
    req = 4'b0100;
    tick();
    check("midrst_gnt", gnt, 4'b0100);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1001;
    check("midrst_gnt_clear", gnt, 0);
    check("midrst_done", done, 0);
    check("midrst_owner", owner, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    serve(0, 5);
    req = '0;

    // Round robin, all requesting with len=2, starting from ptr=0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_len(i, 2);
    req = 4'b1111;
    serve(0, 2);
    serve(1, 2);
    serve(2, 2);
    serve(3, 2);
    serve(0, 2);
    req = '0;
    tick();
    check("directed_err", err, 0);

    // Randomized sweep of the output invariants
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) set_len(i, int'($urandom_range(0, 7)));
      rst = ($urandom_range(0, 49) == 0);
      tick();
      check("rnd_err", err, 0);
      check("rnd_gnt_onehot0", ((gnt & (gnt - 1'b1)) == '0), 1);
      check("rnd_done_onehot0", ((done & (done - 1'b1)) == '0), 1);
      check("rnd_done_gnt_excl", ((done != '0) && (gnt != '0)), 0);
    end
    $display("random sweep cycles=3000");

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
